sprite_tile_dispatcher: RTL
===========================

// Module: sprite_tile_dispatcher
// PURPOSE
//  Upstream feeder for the StreamProcessor pixel array. Accepts sprite descriptors
//  (start_x, z, texture base address) over a valid/ready handshake. Fetches one
//  2x16-pixel, 8-bit-per-pixel texture tile (256 bits) from texture memory as
//  32-bit words, then broadcasts the tile, start_x and z to every pixel with a
//  one-cycle ena pulse. Depth test and transparency (255) stay in the pixels.
// PARAMETERS
//  TEX_ADDR_W  12  texture memory word-address width
//  WORD_W      32  texture read-data width; must divide 256 (WORDS = 256/WORD_W = 8)
// PORTS
//  clk            in   1           single clock, rising edge
//  reset          in   1           asynchronous, active-high reset
//  i_desc_valid   in   1           descriptor valid
//  o_desc_ready   out  1           descriptor ready (high only in IDLE)
//  i_desc_x       in   4           sprite start column
//  i_desc_z       in   8           sprite depth; 0 = background layer
//  i_desc_base    in   TEX_ADDR_W  word address of tile word 0
//  o_tex_rd_en    out  1           texture memory read strobe
//  o_tex_addr     out  TEX_ADDR_W  texture memory word address
//  i_tex_rdata    in   WORD_W      read data, valid exactly 1 cycle after rd_en
//  o_texture_data out  256         assembled tile to pixel array
//  o_start_x      out  4           registered i_desc_x
//  o_position_z   out  8           registered i_desc_z
//  o_ena          out  1           one-cycle broadcast strobe
//  o_busy         out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset (async assert, sync to clk on deassert): state=IDLE; o_desc_ready=1;
//   o_ena, o_tex_rd_en, o_busy=0; o_tex_addr, o_texture_data, o_start_x,
//   o_position_z=0.
//  FSM: IDLE -> FETCH on i_desc_valid&&o_desc_ready (edge E0). Capture x, z, base.
//   FETCH: cycles E0+1..E0+8: o_tex_rd_en=1, o_tex_addr=base+k, k=0..7.
//    -> DRAIN after k=7.
//   DRAIN: one cycle capturing word 7. -> BCAST.
//   BCAST: o_ena=1 for exactly one cycle (E0+10). -> IDLE; ready=1 at E0+11.
//  Fixed latency: accept to o_ena = 10 cycles. Throughput: 1 tile per 11 cycles.
//  Assembly: word k (returned in cycle E0+k+2) goes to o_texture_data[k*32+31:k*32].
//   Pixel index p = row*16+col sits at bits [p*8+7 -: 8], byte 0 = LSB.
//   Row 0 = words 0..3, row 1 = words 4..7.
//  Assemble into a shadow register. Copy it to o_texture_data on entry to BCAST.
//   o_texture_data, o_start_x and o_position_z change only at that edge.
//   They hold stable through o_ena and until the next BCAST.
//  Address arithmetic: modulo 2^TEX_ADDR_W. base+k wraps silently past all-ones.
//  i_desc_valid while busy: ignored; the descriptor is not consumed (ready=0).
//   The upstream holds it.
//  Descriptor fields are passed through untouched: no z filter, no x clamp.
//   z=0 and x=15 are legal.
//  Reset mid-FETCH/DRAIN/BCAST: immediate return to IDLE. The in-flight tile is
//   dropped, no ena is issued, outputs take their reset values.
//   Late read data is ignored.
// STRUCTURE
//  Shared package phosphorus_pkg: TILE_BITS=256, TILE_PIX=32, the
//   WORDS_PER_TILE function of WORD_W, and the dispatcher state enum
//   {IDLE, FETCH, DRAIN, BCAST}.
//  One sub-module: tile_word_assembler. It holds the shadow register and does
//   indexed word writes (write-enable + 3-bit index). The FSM, address counter
//   and output registers stay in this module.
// TESTING
//  1. Reset then single descriptor x=3, z=5, base=0x010, memory word a = {4{a[7:0]}}
//     -> rd_en cycles 1..8, addr 0x010..0x017, ena at cycle 10 only,
//     texture byte p = 0x10+p/4, start_x=3, z=5.
//  2. Back-to-back: valid held high with two descriptors -> second accepted at
//     cycle 11. Second ena at cycle 21. Outputs keep tile 1 between the two enas.
//  3. Address wrap: base=0xFFE -> reads 0xFFE, 0xFFF, 0x000..0x005. Tile words
//     land in order 0..7.
//  4. Valid pulsed during FETCH with a different descriptor -> not accepted,
//     ready=0. Outputs for tile 1 are unaffected.
//  5. Reset asserted at cycle 5 of FETCH -> rd_en=0 and ready=1 immediately.
//     No ena is seen. A descriptor after release completes normally.
//  6. Bench with 4x2 StreamProcessor array: z=0 full tile, then z=7 tile with
//     bytes=255 except pixel 17=0x42 -> only that pixel updates to 0x42.

Source files
------------

// File: rtl/phosphorus_pkg.sv
// Shared constants, tile-geometry helper and dispatcher state encoding.
package phosphorus_pkg;

    localparam int unsigned TILE_BITS = 256;
    localparam int unsigned TILE_PIX  = 32;

    // Number of texture-memory words that make up one tile.
    function automatic int unsigned words_per_tile(input int unsigned word_w);
        return TILE_BITS / word_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        BCAST = 2'd3
    } disp_state_e;

endpackage

// File: rtl/sprite_tile_dispatcher_assembler.sv
// Shadow tile register filled by indexed word writes; exposes its next value
// so the final word can be forwarded in the same cycle it is written.
module tile_word_assembler
    import phosphorus_pkg::*;
#(
    parameter  int unsigned WORD_W = 32,
    localparam int unsigned WORDS  = words_per_tile(WORD_W),
    localparam int unsigned IDX_W  = $clog2(WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_wr_en,
    input  logic [IDX_W-1:0]     i_wr_idx,
    input  logic [WORD_W-1:0]    i_wr_data,
    output logic [TILE_BITS-1:0] o_tile_next_c
);

    logic [TILE_BITS-1:0] tile_q;
    logic [TILE_BITS-1:0] tile_d;

    // Merge the incoming word into its slot of the shadow tile.
    always_comb begin
        tile_d = tile_q;
        if (i_wr_en) begin
            tile_d[32'(i_wr_idx) * WORD_W +: WORD_W] = i_wr_data;
        end
    end

    assign o_tile_next_c = tile_d;

    // Shadow register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tile_q <= '0;
        end else begin
            tile_q <= tile_d;
        end
    end

endmodule

// File: rtl/sprite_tile_dispatcher.sv
// Accepts sprite descriptors, fetches the 256-bit texture tile word by word and
// broadcasts tile, start column and depth to the pixel array with one ena pulse.
module sprite_tile_dispatcher
    import phosphorus_pkg::*;
#(
    parameter int unsigned TEX_ADDR_W = 12,
    parameter int unsigned WORD_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_desc_valid,
    output logic                  o_desc_ready,
    input  logic [3:0]            i_desc_x,
    input  logic [7:0]            i_desc_z,
    input  logic [TEX_ADDR_W-1:0] i_desc_base,
    output logic                  o_tex_rd_en,
    output logic [TEX_ADDR_W-1:0] o_tex_addr,
    input  logic [WORD_W-1:0]     i_tex_rdata,
    output logic [TILE_BITS-1:0]  o_texture_data,
    output logic [3:0]            o_start_x,
    output logic [7:0]            o_position_z,
    output logic                  o_ena,
    output logic                  o_busy
);

    localparam int unsigned WORDS = words_per_tile(WORD_W);
    localparam int unsigned IDX_W = $clog2(WORDS);

    disp_state_e           state_q,   state_d;
    logic [IDX_W-1:0]      k_q,       k_d;
    logic [TEX_ADDR_W-1:0] addr_q,    addr_d;
    logic                  rd_en_q,   rd_en_d;
    logic                  rvalid_q,  rvalid_d;
    logic [IDX_W-1:0]      ridx_q,    ridx_d;
    logic [3:0]            x_pend_q,  x_pend_d;
    logic [7:0]            z_pend_q,  z_pend_d;
    logic [TILE_BITS-1:0]  tex_q,     tex_d;
    logic [3:0]            start_x_q, start_x_d;
    logic [7:0]            pos_z_q,   pos_z_d;
    logic                  ena_q,     ena_d;
    logic                  ready_q,   ready_d;
    logic                  busy_q,    busy_d;
    logic [TILE_BITS-1:0]  tile_next_c;

    tile_word_assembler #(
        .WORD_W (WORD_W)
    ) u_asm (
        .clk           (clk),
        .reset         (reset),
        .i_wr_en       (rvalid_q),
        .i_wr_idx      (ridx_q),
        .i_wr_data     (i_tex_rdata),
        .o_tile_next_c (tile_next_c)
    );

    // Next-state, fetch sequencing and broadcast output logic.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        addr_d    = addr_q;
        rd_en_d   = 1'b0;
        x_pend_d  = x_pend_q;
        z_pend_d  = z_pend_q;
        tex_d     = tex_q;
        start_x_d = start_x_q;
        pos_z_d   = pos_z_q;
        ena_d     = 1'b0;
        // Read data returns one cycle after the strobe; track which word it is.
        rvalid_d  = rd_en_q;
        ridx_d    = k_q;

        unique case (state_q)
            IDLE: begin
                if (i_desc_valid && ready_q) begin
                    state_d  = FETCH;
                    rd_en_d  = 1'b1;
                    addr_d   = i_desc_base;
                    k_d      = '0;
                    x_pend_d = i_desc_x;
                    z_pend_d = i_desc_z;
                end
            end
            FETCH: begin
                if (k_q == IDX_W'(WORDS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    rd_en_d = 1'b1;
                    addr_d  = addr_q + TEX_ADDR_W'(1);
                    k_d     = k_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                // Last word lands this cycle; forward it straight into the output.
                state_d   = BCAST;
                ena_d     = 1'b1;
                tex_d     = tile_next_c;
                start_x_d = x_pend_q;
                pos_z_d   = z_pend_q;
            end
            BCAST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            ridx_q    <= '0;
            x_pend_q  <= '0;
            z_pend_q  <= '0;
            tex_q     <= '0;
            start_x_q <= '0;
            pos_z_q   <= '0;
            ena_q     <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            rvalid_q  <= rvalid_d;
            ridx_q    <= ridx_d;
            x_pend_q  <= x_pend_d;
            z_pend_q  <= z_pend_d;
            tex_q     <= tex_d;
            start_x_q <= start_x_d;
            pos_z_q   <= pos_z_d;
            ena_q     <= ena_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign o_desc_ready   = ready_q;
    assign o_tex_rd_en    = rd_en_q;
    assign o_tex_addr     = addr_q;
    assign o_texture_data = tex_q;
    assign o_start_x      = start_x_q;
    assign o_position_z   = pos_z_q;
    assign o_ena          = ena_q;
    assign o_busy         = busy_q;

endmodule
